// File: rtl/fp_mult_pkg.sv
// Shared definitions for the Avalon-MM pipelined floating-point multiplier:
// register map, status codes and the exponent bias helper.
package fp_mult_pkg;

  localparam logic [2:0] ADDR_OP1    = 3'd0;
  localparam logic [2:0] ADDR_OP2    = 3'd1;
  localparam logic [2:0] ADDR_CTRL   = 3'd2;
  localparam logic [2:0] ADDR_RESULT = 3'd3;
  localparam logic [2:0] ADDR_STATUS = 3'd4;
  localparam logic [2:0] ADDR_COUNT  = 3'd5;

  typedef enum logic [2:0] {
    CODE_OK   = 3'd0,
    CODE_OVF  = 3'd1,
    CODE_UNF  = 3'd2,
    CODE_ZERO = 3'd3,
    CODE_NAN  = 3'd4
  } status_code_t;

  function automatic int fp_bias(input int e);
    return (1 << (e - 1)) - 1;
  endfunction

endpackage

// File: rtl/fp_mult_core.sv
// Combinational floating-point multiply: truncated hidden-one mantissa product,
// 1-bit normalise, biased exponent add and prioritised special-case handling.
module fp_mult_core
  import fp_mult_pkg::*;
#(
  parameter int E = 8,
  parameter int M = 7
) (
  input  logic [E+M:0] a,
  input  logic [E+M:0] b,
  output logic [E+M:0] result,
  output logic [2:0]   code
);

  localparam int XW = E + 2;
  localparam int PW = 2 * M + 2;
  localparam logic [XW-1:0] BIAS_X   = XW'(fp_bias(E));
  localparam logic [XW-1:0] OVF_X    = XW'((1 << E) - 1 + fp_bias(E));
  localparam logic [M-1:0]  QNAN_MAN = M'(1) << (M - 1);

  logic          sa, sb, sign, shift;
  logic [E-1:0]  ea, eb;
  logic [M-1:0]  ma, mb, mant;
  logic [PW-1:0] prod;
  logic [XW-1:0] esum, eres;
  logic          a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, a_den, b_den;
  logic          unused_bits;

  assign {sa, ea, ma} = a;
  assign {sb, eb, mb} = b;
  assign sign  = sa ^ sb;

  assign prod  = PW'({1'b1, ma}) * PW'({1'b1, mb});
  assign shift = prod[PW-1];
  assign mant  = shift ? prod[2*M:M+1] : prod[2*M-1:M];

  assign esum  = XW'(ea) + XW'(eb) + XW'(shift);
  assign eres  = esum - BIAS_X;

  assign a_nan  = (&ea) && (|ma);
  assign b_nan  = (&eb) && (|mb);
  assign a_inf  = (&ea) && !(|ma);
  assign b_inf  = (&eb) && !(|mb);
  assign a_zero = !(|ea) && !(|ma);
  assign b_zero = !(|eb) && !(|mb);
  assign a_den  = !(|ea) && (|ma);
  assign b_den  = !(|eb) && (|mb);

  assign unused_bits = ^{prod[M-1:0], eres[XW-1:E]};

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    result = {sign, eres[E-1:0], mant};
    code   = CODE_OK;
    if (a_nan || b_nan) begin
      result = {sign, {E{1'b1}}, QNAN_MAN};
      code   = CODE_NAN;
    end else if (a_zero || b_zero) begin
      result = '0;
      code   = CODE_ZERO;
    end else if (a_den || b_den || esum <= BIAS_X) begin
      result = {sign, {E{1'b0}}, M'(1)};
      code   = CODE_UNF;
    end else if (esum >= OVF_X || a_inf || b_inf) begin
      result = {sign, {E{1'b1}}, {M{1'b0}}};
      code   = CODE_OVF;
    end
  end

endmodule

// File: rtl/avalon_fp_mult_pipe.sv
// Avalon-MM slave wrapping an LAT-stage floating-point multiplier pipeline and a
// DEPTH-entry result FIFO; issues reserve a FIFO slot so the queue never overflows.
module avalon_fp_mult_pipe
  import fp_mult_pkg::*;
#(
  parameter int E     = 8,
  parameter int M     = 7,
  parameter int LAT   = 3,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [2:0]   avs_s1_address,
  input  logic         avs_s1_read,
  input  logic         avs_s1_write,
  input  logic [E+M:0] avs_s1_writedata,
  output logic [E+M:0] avs_s1_readdata,
  output logic         avs_s1_waitrequest
);

  localparam int W  = 1 + E + M;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  op1, op2, stg_a, stg_b, core_res, push_res;
  logic [2:0]    core_code, push_code, head_code;
  logic          stg_v, push_v, underrun;
  logic [W-1:0]  fifo_data [DEPTH];
  logic [2:0]    fifo_code [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] occ, inflight, total;
  logic          rd_req, issue_req, issue_stall, issue, res_read, res_stall, pop;
  logic          underrun_set, fifo_empty, fifo_full;

  // A simultaneous write wins the bus, so the read side is masked out entirely.
  assign rd_req       = avs_s1_read && !avs_s1_write;
  assign issue_req    = avs_s1_write && avs_s1_address == ADDR_CTRL && avs_s1_writedata[0];
  assign total        = inflight + occ;
  assign fifo_empty   = occ == '0;
  assign fifo_full    = occ == CW'(DEPTH);
  assign issue_stall  = issue_req && total == CW'(DEPTH);
  assign issue        = issue_req && !issue_stall;
  assign res_read     = rd_req && avs_s1_address == ADDR_RESULT;
  assign res_stall    = res_read && fifo_empty && inflight != '0;
  assign pop          = res_read && !fifo_empty;
  assign underrun_set = res_read && fifo_empty && inflight == '0;
  assign head_code    = fifo_empty ? 3'd0 : fifo_code[rd_ptr];

  assign avs_s1_waitrequest = !reset && (issue_stall || res_stall);

  always_comb begin
    avs_s1_readdata = '0;
    if (rd_req && !reset) begin
      case (avs_s1_address)
        ADDR_OP1:    avs_s1_readdata = op1;
        ADDR_OP2:    avs_s1_readdata = op2;
        ADDR_CTRL:   avs_s1_readdata = W'(inflight != '0);
        ADDR_RESULT: avs_s1_readdata = fifo_empty ? '0 : fifo_data[rd_ptr];
        ADDR_STATUS: avs_s1_readdata = W'({underrun, fifo_full, fifo_empty, head_code});
        ADDR_COUNT:  avs_s1_readdata = W'(total);
        default:     avs_s1_readdata = '0;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op1      <= '0;
      op2      <= '0;
      underrun <= 1'b0;
    end else begin
      if (avs_s1_write && avs_s1_address == ADDR_OP1) op1 <= avs_s1_writedata;
      if (avs_s1_write && avs_s1_address == ADDR_OP2) op2 <= avs_s1_writedata;
      if (avs_s1_write && avs_s1_address == ADDR_STATUS) underrun <= 1'b0;
      else if (underrun_set)                             underrun <= 1'b1;
    end
  end

  // Stage 1 keeps private operand copies so OP1/OP2 may be rewritten right after issue.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stg_v <= 1'b0;
      stg_a <= '0;
      stg_b <= '0;
    end else begin
      stg_v <= issue;
      if (issue) begin
        stg_a <= op1;
        stg_b <= op2;
      end
    end
  end

  fp_mult_core #(.E(E), .M(M)) u_core (
    .a      (stg_a),
    .b      (stg_b),
    .result (core_res),
    .code   (core_code)
  );

  if (LAT == 1) begin : g_lat1
    assign push_v    = stg_v;
    assign push_res  = core_res;
    assign push_code = core_code;
  end else begin : g_pipe
    localparam int N = LAT - 1;
    logic [N-1:0] pv;
    logic [W-1:0] pr [N];
    logic [2:0]   pc [N];

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        pv <= '0;
        for (int i = 0; i < N; i++) begin
          pr[i] <= '0;
          pc[i] <= '0;
        end
      end else begin
        pv[0] <= stg_v;
        pr[0] <= core_res;
        pc[0] <= core_code;
        for (int i = 1; i < N; i++) begin
          pv[i] <= pv[i-1];
          pr[i] <= pr[i-1];
          pc[i] <= pc[i-1];
        end
      end
    end

    assign push_v    = pv[N-1];
    assign push_res  = pr[N-1];
    assign push_code = pc[N-1];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inflight <= '0;
      occ      <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      inflight <= inflight + CW'(issue) - CW'(push_v);
      occ      <= occ + CW'(push_v) - CW'(pop);
      if (push_v) wr_ptr <= wr_ptr + AW'(1);
      if (pop)    rd_ptr <= rd_ptr + AW'(1);
    end
  end

  // NOTE: FIFO storage is not reset; occupancy and pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push_v) begin
      fifo_data[wr_ptr] <= push_res;
      fifo_code[wr_ptr] <= push_code;
    end
  end

endmodule

// File: tb/tb_avalon_fp_mult_pipe.sv
// Directed self-checking bench for avalon_fp_mult_pipe at default parameters
// (E=8, M=7, LAT=3, DEPTH=4), driving the Avalon-MM slave port.
module tb_avalon_fp_mult_pipe;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  address = '0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [15:0] writedata = '0;
  logic [15:0] readdata;
  logic        waitrequest;

  int checks = 0;
  int errors = 0;

  avalon_fp_mult_pipe #(.E(8), .M(7), .LAT(3), .DEPTH(4)) dut (
    .clk                (clk),
    .reset              (reset),
    .avs_s1_address     (address),
    .avs_s1_read        (read),
    .avs_s1_write       (write),
    .avs_s1_writedata   (writedata),
    .avs_s1_readdata    (readdata),
    .avs_s1_waitrequest (waitrequest)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Presents a write from a falling edge; gives up (deasserting) after max_stall stalled cycles.
  task automatic bus_write(input logic [2:0] a, input logic [15:0] d, input int max_stall,
                           output int stalls, output logic accepted);
    @(negedge clk);
    address = a; write = 1'b1; writedata = d; stalls = 0;
    #1;
    while (waitrequest && stalls < max_stall) begin
      stalls++;
      @(negedge clk); #1;
    end
    accepted = !waitrequest;
    if (accepted) begin
      @(posedge clk); #1;
    end
    write = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, input string tag, output logic [15:0] d,
                          output int stalls);
    @(negedge clk);
    address = a; read = 1'b1; stalls = 0;
    #1;
    while (waitrequest && stalls < 50) begin
      stalls++;
      @(negedge clk); #1;
    end
    check({tag, "_accept"}, {15'd0, waitrequest}, 16'd0);
    d = readdata;
    if (!waitrequest) begin
      @(posedge clk); #1;
    end
    read = 1'b0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d, input string tag);
    int       s;
    logic     acc;
    bus_write(a, d, 50, s, acc);
    check({tag, "_wr_accept"}, {15'd0, acc}, 16'd1);
  endtask

  task automatic rd(input logic [2:0] a, input string tag, input logic [15:0] expected);
    logic [15:0] d;
    int          s;
    bus_read(a, tag, d, s);
    check(tag, d, expected);
  endtask

  initial begin
    logic [15:0] d;
    int          s;
    logic        acc;

    // Reset state: outputs forced quiet even with a read presented.
    address = 3'd3; read = 1'b1;
    #3;
    check("rst_readdata", readdata, 16'h0000);
    check("rst_waitreq", {15'd0, waitrequest}, 16'h0000);
    read = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    rd(3'd0, "rst_op1", 16'h0000);
    rd(3'd5, "rst_count", 16'h0000);
    rd(3'd4, "rst_status", 16'h0008);
    rd(3'd2, "rst_busy", 16'h0000);

    // 1.5 * 2.0 = 3.0, read immediately: stalls exactly LAT cycles.
    wr(3'd0, 16'h3FC0, "op1");
    wr(3'd1, 16'h4000, "op2");
    rd(3'd0, "op1_readback", 16'h3FC0);
    wr(3'd2, 16'h0001, "issue_a");
    bus_read(3'd3, "lat_read", d, s);
    check("lat_stalls", 16'(s), 16'd3);
    check("lat_result", d, 16'h4040);

    // Same op again, status inspected while the result sits in the FIFO.
    wr(3'd2, 16'h0001, "issue_b");
    rd(3'd2, "busy_after_issue", 16'h0001);
    repeat (2) @(negedge clk);
    rd(3'd4, "status_ok_head", 16'h0000);
    rd(3'd5, "count_one", 16'h0001);
    rd(3'd3, "result_4040", 16'h4040);
    rd(3'd4, "status_drained", 16'h0008);
    rd(3'd2, "busy_idle", 16'h0000);

    // Ignored CTRL write and unmapped address.
    wr(3'd2, 16'h0000, "ctrl_bit0_zero");
    wr(3'd6, 16'hFFFF, "unmapped_wr");
    rd(3'd6, "unmapped_rd", 16'h0000);
    rd(3'd5, "count_no_issue", 16'h0000);

    // Four special-case issues, results popped in order.
    wr(3'd0, 16'h7F00, "ovf_op1"); wr(3'd1, 16'h7F00, "ovf_op2"); wr(3'd2, 16'h0001, "ovf_go");
    wr(3'd0, 16'h0000, "zero_op1"); wr(3'd1, 16'h4000, "zero_op2"); wr(3'd2, 16'h0001, "zero_go");
    wr(3'd0, 16'h7FC0, "nan_op1"); wr(3'd1, 16'h3F80, "nan_op2"); wr(3'd2, 16'h0001, "nan_go");
    wr(3'd0, 16'h0080, "unf_op1"); wr(3'd1, 16'h0080, "unf_op2"); wr(3'd2, 16'h0001, "unf_go");
    repeat (5) @(negedge clk);
    rd(3'd5, "count_four", 16'h0004);
    rd(3'd4, "status_ovf", 16'h0011);
    rd(3'd3, "result_ovf", 16'h7F80);
    rd(3'd4, "status_zero", 16'h0003);
    rd(3'd3, "result_zero", 16'h0000);
    rd(3'd4, "status_nan", 16'h0004);
    bus_read(3'd3, "result_nan", d, s);
    check("result_nan_exp", d & 16'h7F80, 16'h7F80);
    rd(3'd4, "status_unf", 16'h0002);
    rd(3'd3, "result_unf", 16'h0001);
    rd(3'd4, "status_after_specials", 16'h0008);

    // Reservation: fifth issue stalls until a slot is popped.
    wr(3'd0, 16'h3F80, "one_op1");
    wr(3'd1, 16'h3F80, "one_op2");
    for (int i = 0; i < 4; i++) wr(3'd2, 16'h0001, "fill_go");
    repeat (4) @(negedge clk);
    rd(3'd5, "count_full", 16'h0004);
    rd(3'd4, "status_full", 16'h0010);
    bus_write(3'd2, 16'h0001, 6, s, acc);
    check("fifth_stalled", {15'd0, acc}, 16'd0);
    check("fifth_stall_cycles", 16'(s), 16'd6);
    rd(3'd5, "count_capped", 16'h0004);
    rd(3'd3, "pop_frees_slot", 16'h3F80);
    bus_write(3'd2, 16'h0001, 50, s, acc);
    check("fifth_accepted", {15'd0, acc}, 16'd1);
    check("fifth_no_stall", 16'(s), 16'd0);
    rd(3'd5, "count_refilled", 16'h0004);
    for (int i = 0; i < 4; i++) rd(3'd3, "drain_result", 16'h3F80);
    rd(3'd5, "count_drained", 16'h0000);

    // Underrun on idle empty read, cleared by any STATUS write.
    bus_read(3'd3, "underrun_read", d, s);
    check("underrun_data", d, 16'h0000);
    check("underrun_no_stall", 16'(s), 16'd0);
    rd(3'd4, "status_underrun", 16'h0028);
    wr(3'd4, 16'h0000, "status_clear");
    rd(3'd4, "status_cleared", 16'h0008);

    // Reset with two operations inflight discards everything.
    wr(3'd2, 16'h0001, "pre_rst_go1");
    wr(3'd2, 16'h0001, "pre_rst_go2");
    @(negedge clk);
    reset = 1'b1; address = 3'd3; read = 1'b1;
    #1;
    check("midrst_readdata", readdata, 16'h0000);
    check("midrst_waitreq", {15'd0, waitrequest}, 16'h0000);
    @(negedge clk);
    read = 1'b0; reset = 1'b0;
    rd(3'd5, "post_rst_count", 16'h0000);
    rd(3'd2, "post_rst_busy", 16'h0000);
    rd(3'd0, "post_rst_op1", 16'h0000);
    repeat (10) @(negedge clk);
    rd(3'd5, "post_rst_count_late", 16'h0000);
    rd(3'd4, "post_rst_status", 16'h0008);
    rd(3'd3, "post_rst_result", 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/avalon_fp_mult_pipe.md
AVALON_FP_MULT_PIPE -- requirements
Module: avalon_fp_mult_pipe

Interface
REQ-001 Parameter E, default 8, exponent bits.
REQ-002 Parameter M, default 7, mantissa bits; W = 1+E+M is the data width.
REQ-003 Parameter LAT, default 3, multiplier pipeline stages; legal range 1..8.
REQ-004 Parameter DEPTH, default 4, result FIFO entries; power of two, 2..16.
REQ-005 clk  in  1  single system clock; all logic on rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 avs_s1_address  in  3  register select.
REQ-008 avs_s1_read  in  1  read request.
REQ-009 avs_s1_write  in  1  write request.
REQ-010 avs_s1_writedata  in  W  write data.
REQ-011 avs_s1_readdata  out  W  combinational read mux, zero when no read.
REQ-012 avs_s1_waitrequest  out  1  stall; the transfer is accepted on the edge where it is low.

Function
REQ-013 Register map:
- 0 OP1 r/w.
- 1 OP2 r/w.
- 2 CTRL: write with bit0=1 issues; reads return the busy flag (inflight>0).
- 3 RESULT: read pops the FIFO head.
- 4 STATUS: read returns {underrun, full, empty, code[2:0]}; any write clears underrun.
- 5 COUNT: read returns inflight+occupancy.
- 6 and 7: reads return 0; writes are ignored.
REQ-014 Issue: on an accepted CTRL write with bit0=1, the current OP1/OP2 enter pipeline stage 1; a write with bit0=0 is ignored.
REQ-015 A CTRL issue with inflight+occupancy == DEPTH shall hold waitrequest high until a slot frees; the issue is then accepted on that edge.
REQ-016 Writes to OP1/OP2 never stall; the pipeline holds its own operand copies, so rewriting them after issue is legal.
REQ-017 Throughput is one issue per clock; an issue accepted at edge k makes its result readable at RESULT from the cycle after edge k+LAT.
REQ-018 Stage 1 is the combinational multiply. Stages 2..LAT are registers carrying {result, code} and a valid bit. The final stage pushes into the FIFO.
REQ-019 Core arithmetic:
- sign = sx^sy.
- Product of hidden-one mantissas, truncated, with 1-bit normalise shift.
- exp = ex+ey+shift-bias, where bias = 2^(E-1)-1.
REQ-020 Special cases, in priority order, with code:
- NaN (exp all ones, mant != 0): code 4, exp all ones.
- Zero operand: code 3, result all zero.
- Denormal operand, or ex+ey+shift <= bias: code 2, exp 0, mant 1.
- Exp >= all ones, or an infinite operand: code 1, exp all ones, mant 0.
- Otherwise: code 0.
REQ-021 RESULT read when the FIFO is empty and inflight>0 shall hold waitrequest high until data arrives.
REQ-022 RESULT read when the FIFO is empty and inflight==0 returns 0, does not stall, does not pop, and sets sticky underrun.
REQ-023 A pipeline push and a RESULT pop on the same edge both take effect; occupancy is unchanged.
REQ-024 FIFO pointers wrap modulo DEPTH; overflow cannot occur, because of the REQ-015 reservation.
REQ-025 Simultaneous read and write: the write has priority, waitrequest is evaluated for the write, and the read is ignored.
REQ-026 STATUS.code reflects the FIFO head; it is 0 when the FIFO is empty.

Reset
REQ-027 Reset clears:
- OP1 and OP2.
- All pipeline valid bits and data.
- FIFO pointers and occupancy.
- The underrun flag.
REQ-028 Outputs during reset: readdata 0, waitrequest 0. Reset mid-operation discards all inflight and queued results.

Structure
REQ-029 Package fp_mult_pkg holds:
- The register address constants.
- The status code enum (OK, OVF, UNF, ZERO, NAN).
- The bias function.
REQ-030 The combinational multiplier is the sub-module fp_mult_core #(E,M), instantiated once in stage 1. The pipeline and FIFO are local to the top.

Verification
REQ-031 Default params: write OP1=0x3FC0, OP2=0x4000, CTRL=1; then RESULT=0x4040 and STATUS.code=0, LAT cycles after issue.
REQ-032 Four back-to-back issues (0x7F00x0x7F00, 0x0000x0x4000, 0x7FC0x0x3F80, 0x0080x0x0080) shall return, in order:
- 0x7F80, code 1.
- 0x0000, code 3.
- exp 0xFF, code 4.
- 0x0001, code 2.
REQ-033 Issue 5 ops without reading (DEPTH=4): the 5th CTRL write stalls until one RESULT pop, and COUNT never exceeds 4.
REQ-034 RESULT read immediately after issue stalls for LAT cycles, then returns the result.
REQ-035 A RESULT read while idle and empty returns 0 and sets STATUS bit5; a STATUS write clears it.
REQ-036 Assert reset with 2 ops inflight: COUNT=0, busy=0, and no results appear afterwards.
